// File: rtl/sram_like_pkg.sv
// Shared types and limits for the sram-like responder and its response queue.
package sram_like_pkg;

  // Transfer size encodings carried on the request (informational only).
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Legal parameter ranges.
  localparam int MAX_ADDR_DELAY  = 15;
  localparam int MIN_DATA_DELAY  = 1;
  localparam int MAX_DATA_DELAY  = 15;
  localparam int MIN_OUTSTANDING = 1;
  localparam int MAX_OUTSTANDING = 4;

  // Widths sized for the maximum limits above.
  localparam int TIMER_W = 4;
  localparam int PTR_W   = 2;
  localparam int CNT_W   = 3;

  // One pending response: captured read data plus cycles left before retire.
  typedef struct packed {
    logic [31:0]        rdata;
    logic [TIMER_W-1:0] timer;
  } resp_entry_t;

  localparam int RESP_ENTRY_W = $bits(resp_entry_t);

  // Circular pointer advance that wraps at the configured queue depth.
  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p, int depth);
    return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: each entry counts down its own latency timer and
// the head retires once its timer has reached zero.
module sram_like_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic [RESP_ENTRY_W-1:0] push_entry,
  input  logic                    pop,
  output logic                    head_valid,
  output logic [RESP_ENTRY_W-1:0] head_entry,
  output logic [CNT_W-1:0]        count
);

  // Storage is sized for the maximum depth so pointers index it without
  // width games; only the first OUTSTANDING slots are ever used.
  resp_entry_t      ent_q   [MAX_OUTSTANDING];
  resp_entry_t      ent_d   [MAX_OUTSTANDING];
  logic             valid_q [MAX_OUTSTANDING];
  logic             valid_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop     = pop && valid_q[head_q];
  assign do_push    = push && (count_q < CNT_W'(OUTSTANDING));
  assign head_valid = valid_q[head_q];
  assign head_entry = ent_q[head_q];
  assign count      = count_q;

  // Next state: age every pending timer, then apply pop and push.
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      valid_d[i] = valid_q[i];
      ent_d[i]   = ent_q[i];
      if (valid_q[i] && (ent_q[i].timer != '0)) begin
        ent_d[i].timer = ent_q[i].timer - 1'b1;
      end
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q, OUTSTANDING);
    end
    if (do_push) begin
      valid_d[tail_q] = 1'b1;
      ent_d[tail_q]   = push_entry;
      tail_d          = ptr_inc(tail_q, OUTSTANDING);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Per-slot registers; reset discards every pending response.
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        valid_q[gi] <= 1'b0;
        ent_q[gi]   <= '0;
      end else begin
        valid_q[gi] <= valid_d[gi];
        ent_q[gi]   <= ent_d[gi];
      end
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Responder side of the sram-like memory interface with programmable address
// wait states and response latency, up to OUTSTANDING responses in flight.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int DEPTH       = 65536,
  parameter int ADDR_DELAY  = 0,
  parameter int DATA_DELAY  = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]             mem [DEPTH];
  logic [IDX_W-1:0]        idx;
  logic [31:0]             mem_rd;
  logic [TIMER_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]        count;
  logic                    accept;
  logic                    head_valid;
  logic [RESP_ENTRY_W-1:0] head_bits;
  resp_entry_t             head_entry;
  resp_entry_t             push_entry;
  logic                    unused_ok;

  // Size and the address bits outside the word index do not affect behaviour.
  assign unused_ok = ^{size, addr[31:IDX_W+2], addr[1:0]};

  assign idx    = addr[IDX_W+1:2];
  // Read sees the array before this cycle's write lands at the clock edge.
  assign mem_rd = mem[idx];

  // Accept only from registered state so a same-cycle retire cannot free a slot.
  assign addr_ok = resetn && req && (wcnt_q == TIMER_W'(ADDR_DELAY))
                   && (count < CNT_W'(OUTSTANDING));
  assign accept  = addr_ok;

  assign push_entry.rdata = wr ? 32'h0 : mem_rd;
  assign push_entry.timer = TIMER_W'(DATA_DELAY - 1);

  assign head_entry = resp_entry_t'(head_bits);
  assign data_ok    = head_valid && (head_entry.timer == '0);
  assign rdata      = data_ok ? head_entry.rdata : 32'h0;

  // Address wait counter: restarts when req drops or a request is taken.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!req || accept) begin
      wcnt_d = '0;
    end else if (wcnt_q != TIMER_W'(ADDR_DELAY)) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // Byte-masked write on acceptance; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  sram_like_resp_fifo #(
    .OUTSTANDING(OUTSTANDING)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (data_ok),
    .head_valid (head_valid),
    .head_entry (head_bits),
    .count      (count)
  );

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Responder (slave) side of the core's sram-like memory interface: accepts address-phase requests with `req`/`addr_ok`, holds up to `OUTSTANDING` accepted transactions in order, and returns each one with a single-cycle `data_ok` (plus `rdata` for reads) after a programmable latency. It stands in for instruction or data memory behind the core's sram-like ports in simulation and FPGA tests, and adds controlled address and data wait states that the plain one-cycle SRAM never produces.

## Interface
- `DEPTH`, 65536 — memory size in 32-bit words; power of two.
- `ADDR_DELAY`, 0 — cycles `req` must be held high before `addr_ok` may rise; 0..15.
- `DATA_DELAY`, 1 — minimum cycles from acceptance to `data_ok`; 1..15.
- `OUTSTANDING`, 2 — accepted-but-unanswered transaction limit; 1..4.
- `clk  in  1` — clock, rising edge.
- `resetn  in  1` — asynchronous reset, active low.
- `req  in  1` — request valid; held with its fields until `addr_ok`.
- `wr  in  1` — 1 = write, 0 = read.
- `size  in  2` — 0 byte, 1 half, 2 word; informational only.
- `wstrb  in  4` — write byte enables; ignored for reads.
- `addr  in  32` — byte address; word index = `addr[log2(DEPTH)+1:2]`, other bits ignored.
- `wdata  in  32` — write data.
- `addr_ok  out  1` — request accepted this cycle when `req && addr_ok`.
- `data_ok  out  1` — one-cycle response pulse, in acceptance order.
- `rdata  out  32` — read data, valid when `data_ok` for a read; 0 for write responses.

## Operation
- Acceptance (handshake) in cycle c: `req && addr_ok` high.
- Wait counter `wcnt`: cleared on reset, on acceptance, or while `req`=0; otherwise increments while `req`=1, saturating at `ADDR_DELAY`.
- `addr_ok = req && (wcnt == ADDR_DELAY) && (count < OUTSTANDING)`. Combinational from registered state only; no dependence on a same-cycle retire.
- Write on acceptance: bytes of `mem[index]` with `wstrb[i]`=1 take `wdata[8i+7:8i]` at the end of cycle c. Queue entry has `rdata` = 0.
- Read on acceptance: queue entry captures `mem[index]` as it stands before any write in cycle c. A read accepted after a write to the same word sees the new data.
- Queue: in-order FIFO of `OUTSTANDING` entries {`rdata[31:0]`, `timer[3:0]`}. `timer` loads `DATA_DELAY-1` on push. Every cycle, every valid entry with `timer>0` decrements.
- Retire: `data_ok = head_valid && head.timer == 0`; `rdata = head.rdata` when `data_ok`, else 0. The head pops at the end of that cycle.
- Push and pop in the same cycle are allowed; `count` is unchanged.
- Memory contents are not reset.

## Timing
- Reset (asynchronous assert): `addr_ok`=0, `data_ok`=0, `rdata`=0, queue empty, `wcnt`=0.
- Reset mid-transaction: all outstanding responses are discarded and no `data_ok` follows. A write already accepted stays in memory.
- With `ADDR_DELAY`=0 and queue not full, `addr_ok` is high in the first cycle `req` is high.
- Request accepted in cycle c with an empty queue ahead gives `data_ok` in cycle c+`DATA_DELAY`. If older entries are still pending, `data_ok` comes no earlier than the cycle after the older entry's `data_ok`.
- Back-to-back `data_ok` pulses are allowed.
- Queue full: `addr_ok`=0 even if the head retires that cycle. `addr_ok` may rise the next cycle.
- There is no backpressure on responses; the initiator must always accept `data_ok`.

## Structure
- Shared package `sram_like_pkg` holds:
  - size encodings `SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=2;
  - the queue-entry struct/width constant;
  - the parameter limit constants.
- Sub-module `sram_like_resp_fifo` holds the in-order response queue: entries, timers, `count`, push/pop, head outputs.
- Top level holds the memory array, the wait counter, and the `addr_ok` logic.

## Test plan
- Single read, `ADDR_DELAY`=0, `DATA_DELAY`=1:
  - preload `mem[4]`=0x12345678;
  - read `addr`=0x10 in cycle 0 → `addr_ok` high in cycle 0, `data_ok` high in cycle 1 with `rdata`=0x12345678.
- Byte write then read:
  - write `addr`=0x10, `wstrb`=0010, `wdata`=0x0000AB00 over 0x12345678;
  - next-cycle read of 0x10 → `rdata`=0x1234AB78;
  - write response has `rdata`=0.
- Address wait: `ADDR_DELAY`=3, `req` held from cycle 0 → `addr_ok` first high in cycle 3; dropping `req` in cycle 2 restarts the count.
- Outstanding limit: `OUTSTANDING`=2, `DATA_DELAY`=4, reads issued every cycle from cycle 0:
  - accepted in cycles 0 and 1, `addr_ok`=0 in cycles 2–4;
  - `data_ok` in cycles 4 and 5, third acceptance in cycle 5;
  - responses in issue order.
- Reset mid-flight: assert `resetn`=0 in cycle 2 with two pending reads → `data_ok`, `addr_ok`, `rdata` all 0 immediately and no stray `data_ok` after release.
- Simultaneous push/pop with queue at `count`=1 → accept and retire in the same cycle, `count` stays 1, and data order is preserved.
